ysyx_23060187_ifu: RTL

YSYX_23060187_IFU -- requirements
Module: ysyx_23060187_ifu

---
 rtl/ysyx_23060187_ifu.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060187_ifu.sv
// ysyx_23060187_ifu: instruction fetch unit.
// Walks FETCH -> WAIT -> OUT once per instruction. It keeps at most one
// memory request in flight and drops the stale response when a redirect
// overtakes an accepted request.
module ysyx_23060187_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        drop_q, drop_d;
  logic        req_fire;
  logic        inst_fire;

  // The request is held off while reset is asserted and while a stale response is still owed.
  assign imem_req_valid = rst_n && (state_q == S_FETCH) && !drop_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_cnt      = fetch_cnt_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inst_fire      = inst_valid && inst_ready;

  // Next-state logic. The normal handshake flow is computed first, then a redirect overrides it.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    drop_d      = drop_q;

    case (state_q)
      S_FETCH: begin
        if (drop_q) begin
          if (imem_resp_valid) begin
            drop_d = 1'b0;
          end
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_fire) begin
          state_d     = S_FETCH;
          pc_d        = pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (redirect_valid) begin
      state_d     = S_FETCH;
      pc_d        = {redirect_pc[31:2], 2'b00};
      fetch_cnt_d = fetch_cnt_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      // In WAIT, a response arriving this same cycle is the one being discarded, so nothing is owed afterwards.
      if (state_q == S_WAIT) begin
        drop_d = !imem_resp_valid;
      end else if (req_fire) begin
        drop_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
      fetch_cnt_q <= 32'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      drop_q      <= drop_d;
    end
  end

endmodule
